// File: rtl/tt_wb_ctrl_pkg.sv
// Shared definitions for the TT Wishbone control block: register offsets,
// CTRL/STATUS bit positions, sequencer state encoding and a byte-lane helper.
package tt_wb_ctrl_pkg;

   // Word offsets inside the 16-byte window, taken from address bits [3:2]
   localparam logic [1:0] REG_CTRL    = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_SCRATCH = 2'd2;
   localparam logic [1:0] REG_RSVD    = 2'd3;

   // CTRL bit positions; the target field occupies [ADDR_W-1:0]
   localparam int CTRL_ENA_BIT    = 16;
   localparam int CTRL_IRQ_EN_BIT = 17;
   localparam int CTRL_GO_BIT     = 31;

   // STATUS bit positions; the current count occupies [16+ADDR_W-1:16]
   localparam int STAT_BUSY_BIT  = 0;
   localparam int STAT_DONE_BIT  = 1;
   localparam int STAT_ERR_BIT   = 2;
   localparam int STAT_COUNT_LSB = 16;

   // Width of the per-phase cycle counter inside the sequencer
   localparam int CYC_W = 16;

   // Sequencer states: select-counter reset, increment pulse high/low, enable
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RST    = 3'd1,
      ST_INC_HI = 3'd2,
      ST_INC_LO = 3'd3,
      ST_ENA    = 3'd4
   } seqState_e;

   // Replace each byte of oldVal whose byte enable is set with the byte of newVal
   function automatic logic [31:0] byteMerge(input logic [31:0] oldVal,
                                             input logic [31:0] newVal,
                                             input logic [3:0]  sel);
      logic [31:0] result;
      result = oldVal;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) begin
            result[b*8 +: 8] = newVal[b*8 +: 8];
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/tt_wb_ctrl_seq.sv
// Mux select sequencer: holds the select counter in reset, emits one
// increment pulse per step up to the latched target, then drives the enable.
// All mux-facing outputs are registered from the next state so they line up
// with the state register and come out of reset with rst_n low.
module tt_wb_ctrl_seq
   import tt_wb_ctrl_pkg::*;
#(
   parameter int ADDR_W    = 10,
   parameter int RST_CYC   = 4,
   parameter int PULSE_CYC = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] target_i,
   input  logic              ena_i,
   output logic              selRstN_o,
   output logic              selInc_o,
   output logic              ctrlEna_o,
   output logic              idle_o,
   output logic              busy_o,
   output logic              doneSet_o,
   output logic [ADDR_W-1:0] count_o
);

   seqState_e         state_q, state_d;
   logic [CYC_W-1:0]  cyc_q, cyc_d;
   logic [ADDR_W-1:0] count_q, count_d;
   logic [ADDR_W-1:0] target_q, target_d;
   logic              ena_q, ena_d;
   logic              ctrlEna_q, ctrlEna_d;
   logic              selRstN_q;
   logic              selInc_q;

   // Next-state logic: phase lengths are timed by cyc_q, steps by count_q
   always_comb begin
      state_d   = state_q;
      cyc_d     = cyc_q;
      count_d   = count_q;
      target_d  = target_q;
      ena_d     = ena_q;
      ctrlEna_d = ctrlEna_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               target_d  = target_i;
               ena_d     = ena_i;
               ctrlEna_d = 1'b0;
               count_d   = '0;
               cyc_d     = '0;
               state_d   = ST_RST;
            end
         end
         ST_RST: begin
            if (cyc_q == CYC_W'(RST_CYC - 1)) begin
               cyc_d   = '0;
               state_d = (target_q == '0) ? ST_ENA : ST_INC_HI;
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         ST_INC_HI: begin
            if (cyc_q == CYC_W'(PULSE_CYC - 1)) begin
               cyc_d   = '0;
               state_d = ST_INC_LO;
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         ST_INC_LO: begin
            if (cyc_q == CYC_W'(PULSE_CYC - 1)) begin
               cyc_d   = '0;
               count_d = count_q + 1'b1;
               state_d = ((count_q + 1'b1) == target_q) ? ST_ENA : ST_INC_HI;
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         ST_ENA: begin
            ctrlEna_d = ena_q;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any sequence in progress
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         cyc_q     <= '0;
         count_q   <= '0;
         target_q  <= '0;
         ena_q     <= 1'b0;
         ctrlEna_q <= 1'b0;
         selRstN_q <= 1'b0;
         selInc_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cyc_q     <= cyc_d;
         count_q   <= count_d;
         target_q  <= target_d;
         ena_q     <= ena_d;
         ctrlEna_q <= ctrlEna_d;
         selRstN_q <= (state_d != ST_RST);
         selInc_q  <= (state_d == ST_INC_HI);
      end
   end

   assign selRstN_o = selRstN_q;
   assign selInc_o  = selInc_q;
   assign ctrlEna_o = ctrlEna_q;
   assign idle_o    = (state_q == ST_IDLE);
   assign busy_o    = (state_q == ST_RST) || (state_q == ST_INC_HI) || (state_q == ST_INC_LO);
   assign doneSet_o = (state_q == ST_ENA);
   assign count_o   = count_q;

endmodule

// File: rtl/tt_wb_ctrl.sv
// Wishbone classic responder for the TT mux: decodes a 16-byte window,
// acks each access one cycle after the request and holds CTRL, STATUS and
// SCRATCH. A go write starts the select sequencer in tt_wb_ctrl_seq.
// Optional feature macro: TT_WB_CTRL_IRQ_EN enables CTRL.irq_en and irq_o.
module tt_wb_ctrl
   import tt_wb_ctrl_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          ADDR_W    = 10,
   parameter int          RST_CYC   = 4,
   parameter int          PULSE_CYC = 2
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [31:0] wbs_adr_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        ctrl_sel_rst_n,
   output logic        ctrl_sel_inc,
   output logic        ctrl_ena,
   output logic        irq_o
);

   logic              match;
   logic              req;
   logic              wrEn;
   logic              rdEn;
   logic              goReq;
   logic              seqStart;
   logic              seqIdle;
   logic              seqBusy;
   logic              seqDoneSet;
   logic [ADDR_W-1:0] seqCount;
   logic [1:0]        regSel;
   logic              irqEnRd;
   logic [31:0]       ctrlCur;
   logic [31:0]       ctrlMerged;
   logic [31:0]       rdData;
   logic              unusedBits;

   logic              ack_q;
   logic [31:0]       dat_q, dat_d;
   logic [31:0]       scratch_q, scratch_d;
   logic [ADDR_W-1:0] target_q, target_d;
   logic              ena_q, ena_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
`ifdef TT_WB_CTRL_IRQ_EN
   logic              irqEn_q, irqEn_d;
   logic              irq_q;
`endif

   assign match    = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
   assign req      = wbs_stb_i & wbs_cyc_i & match & ~ack_q;
   assign wrEn     = req & wbs_we_i;
   assign rdEn     = req & ~wbs_we_i;
   assign regSel   = wbs_adr_i[3:2];
   assign goReq    = wrEn & (regSel == REG_CTRL) & wbs_sel_i[3] & wbs_dat_i[CTRL_GO_BIT];
   assign seqStart = goReq & seqIdle;

`ifdef TT_WB_CTRL_IRQ_EN
   assign irqEnRd = irqEn_q;
`else
   assign irqEnRd = 1'b0;
`endif

   // Current CTRL view and its byte-lane merge with the incoming write data
   always_comb begin
      ctrlCur                  = '0;
      ctrlCur[ADDR_W-1:0]      = target_q;
      ctrlCur[CTRL_ENA_BIT]    = ena_q;
      ctrlCur[CTRL_IRQ_EN_BIT] = irqEnRd;
      ctrlMerged               = byteMerge(ctrlCur, wbs_dat_i, wbs_sel_i);
   end

   // Register writes; sticky set events take priority over write-one-to-clear
   always_comb begin
      scratch_d = scratch_q;
      target_d  = target_q;
      ena_d     = ena_q;
      done_d    = done_q;
      err_d     = err_q;
`ifdef TT_WB_CTRL_IRQ_EN
      irqEn_d   = irqEn_q;
`endif
      if (wrEn) begin
         case (regSel)
            REG_CTRL: begin
               target_d = ctrlMerged[ADDR_W-1:0];
               ena_d    = ctrlMerged[CTRL_ENA_BIT];
`ifdef TT_WB_CTRL_IRQ_EN
               irqEn_d  = ctrlMerged[CTRL_IRQ_EN_BIT];
`endif
            end
            REG_STATUS: begin
               if (wbs_sel_i[0]) begin
                  if (wbs_dat_i[STAT_DONE_BIT]) done_d = 1'b0;
                  if (wbs_dat_i[STAT_ERR_BIT])  err_d  = 1'b0;
               end
            end
            REG_SCRATCH: begin
               scratch_d = byteMerge(scratch_q, wbs_dat_i, wbs_sel_i);
            end
            default: begin
            end
         endcase
      end
      if (goReq && !seqIdle) err_d  = 1'b1;
      if (seqDoneSet)        done_d = 1'b1;
   end

   // Read multiplexer; data is only presented alongside the ack
   always_comb begin
      rdData = '0;
      case (regSel)
         REG_CTRL: begin
            rdData = ctrlCur;
         end
         REG_STATUS: begin
            rdData[STAT_BUSY_BIT]                = seqBusy;
            rdData[STAT_DONE_BIT]                = done_q;
            rdData[STAT_ERR_BIT]                 = err_q;
            rdData[STAT_COUNT_LSB +: ADDR_W]     = seqCount;
         end
         REG_SCRATCH: begin
            rdData = scratch_q;
         end
         default: begin
            rdData = '0;
         end
      endcase
      dat_d = rdEn ? rdData : '0;
   end

   // Bus response and register state, synchronous reset
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q     <= 1'b0;
         dat_q     <= '0;
         scratch_q <= '0;
         target_q  <= '0;
         ena_q     <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         ack_q     <= req;
         dat_q     <= dat_d;
         scratch_q <= scratch_d;
         target_q  <= target_d;
         ena_q     <= ena_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

`ifdef TT_WB_CTRL_IRQ_EN
   // Interrupt enable bit and registered done interrupt
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         irqEn_q <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         irqEn_q <= irqEn_d;
         irq_q   <= done_q & irqEn_q;
      end
   end
   assign irq_o = irq_q;
`else
   assign irq_o = 1'b0;
`endif

   tt_wb_ctrl_seq #(
      .ADDR_W    (ADDR_W),
      .RST_CYC   (RST_CYC),
      .PULSE_CYC (PULSE_CYC)
   ) u_seq (
      .clk_i     (wb_clk_i),
      .rst_i     (wb_rst_i),
      .start_i   (seqStart),
      .target_i  (target_d),
      .ena_i     (ena_d),
      .selRstN_o (ctrl_sel_rst_n),
      .selInc_o  (ctrl_sel_inc),
      .ctrlEna_o (ctrl_ena),
      .idle_o    (seqIdle),
      .busy_o    (seqBusy),
      .doneSet_o (seqDoneSet),
      .count_o   (seqCount)
   );

   assign wbs_ack_o  = ack_q;
   assign wbs_dat_o  = dat_q;
   assign unusedBits = &{1'b0, wbs_adr_i[1:0], ctrlMerged};

endmodule

// File: tb/tb_tt_wb_ctrl.sv
// Self-checking bench for tt_wb_ctrl with a register-level reference model.
module tb_tt_wb_ctrl;

   localparam logic [31:0] BASE      = 32'h3000_0000;
   localparam int          ADDR_W    = 10;
   localparam int          RST_CYC   = 4;
   localparam int          PULSE_CYC = 2;
`ifdef TT_WB_CTRL_IRQ_EN
   localparam bit          IRQ_BUILD = 1'b1;
`else
   localparam bit          IRQ_BUILD = 1'b0;
`endif
   localparam logic [31:0] CTRL_MASK = (32'd1 << ADDR_W) - 32'd1 | 32'h0001_0000
                                       | (IRQ_BUILD ? 32'h0002_0000 : 32'h0);
   localparam logic [31:0] A_CTRL    = BASE + 32'h0;
   localparam logic [31:0] A_STATUS  = BASE + 32'h4;
   localparam logic [31:0] A_SCRATCH = BASE + 32'h8;
   localparam logic [31:0] A_RSVD    = BASE + 32'hC;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stb = 1'b0;
   logic        cyc = 1'b0;
   logic        we  = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] datIn = '0;
   logic [31:0] adr = '0;
   logic        ack;
   logic [31:0] datOut;
   logic        selRstN, selInc, ena, irq;

   int checks   = 0;
   int failures = 0;

   // Reference model state: CTRL as stored (masked), STATUS sticky bits, scratch
   logic [31:0] mCtrl    = '0;
   logic [31:0] mScratch = '0;
   logic        mDone    = 1'b0;
   logic        mErr     = 1'b0;
   int          mCount   = 0;

   tt_wb_ctrl dut (
      .wb_clk_i       (clk),
      .wb_rst_i       (rst),
      .wbs_stb_i      (stb),
      .wbs_cyc_i      (cyc),
      .wbs_we_i       (we),
      .wbs_sel_i      (sel),
      .wbs_dat_i      (datIn),
      .wbs_adr_i      (adr),
      .wbs_ack_o      (ack),
      .wbs_dat_o      (datOut),
      .ctrl_sel_rst_n (selRstN),
      .ctrl_sel_inc   (selInc),
      .ctrl_ena       (ena),
      .irq_o          (irq)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal, input logic [31:0] newVal,
                                              input logic [3:0] be);
      logic [31:0] r;
      r = oldVal;
      for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = newVal[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [31:0] expStatus();
      return (32'(mCount) << 16) | (32'(mErr) << 2) | (32'(mDone) << 1);
   endfunction

   function automatic logic [31:0] expCtrl();
      return mCtrl;
   endfunction

   task automatic modelReset();
      mCtrl = '0; mScratch = '0; mDone = 1'b0; mErr = 1'b0; mCount = 0;
   endtask

   task automatic wbWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      bit gotAck;
      gotAck = 1'b0;
      adr = a; datIn = d; sel = be; we = 1'b1; stb = 1'b1; cyc = 1'b1;
      for (int k = 0; k < 4 && !gotAck; k++) begin
         @(negedge clk);
         if (ack) gotAck = 1'b1;
      end
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      checkOutput("write ack", {31'b0, gotAck}, 32'd1);
   endtask

   task automatic wbRead(input logic [31:0] a, output logic [31:0] d);
      bit gotAck;
      gotAck = 1'b0;
      d = 32'hDEAD_BEEF;
      adr = a; sel = 4'hF; we = 1'b0; stb = 1'b1; cyc = 1'b1;
      for (int k = 0; k < 4 && !gotAck; k++) begin
         @(negedge clk);
         if (ack) begin
            gotAck = 1'b1;
            d = datOut;
         end
      end
      stb = 1'b0; cyc = 1'b0;
      checkOutput("read ack", {31'b0, gotAck}, 32'd1);
   endtask

   task automatic readCheck(input string tag, input logic [31:0] a, input logic [31:0] expected);
      logic [31:0] d;
      wbRead(a, d);
      checkOutput(tag, d, expected);
   endtask

   // Model effect of a CTRL write; returns whether it should start a sequence
   task automatic modelCtrlWrite(input logic [31:0] d, input logic [3:0] be, input bit idle);
      mCtrl = mergeBytes(mCtrl, d, be) & CTRL_MASK;
      if (be[3] && d[31]) begin
         if (idle) mCount = 0;
         else      mErr   = 1'b1;
      end
   endtask

   // Watch the mux outputs from the go-ack sample onward and compare against
   // the protocol timeline derived from RST_CYC, PULSE_CYC and the target
   task automatic observeSeq(input int tgt, input bit enaExp);
      int n, j, rstLow, incHi, rises, badRst, badInc, badEna, enaIdx;
      bit prevInc, expInc, expEna;
      n = RST_CYC + 2*PULSE_CYC*tgt + 3;
      enaIdx = RST_CYC + 2*PULSE_CYC*tgt + 1;
      rstLow = 0; incHi = 0; rises = 0; badRst = 0; badInc = 0; badEna = 0; prevInc = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge clk);
         j = i - RST_CYC;
         expInc = (j >= 0) && (j < 2*PULSE_CYC*tgt) && ((j % (2*PULSE_CYC)) < PULSE_CYC);
         expEna = enaExp && (i >= enaIdx);
         if (selRstN !== (i >= RST_CYC)) badRst++;
         if (selInc !== expInc) badInc++;
         if (ena !== expEna) badEna++;
         if (!selRstN) rstLow++;
         if (selInc) incHi++;
         if (selInc && !prevInc) rises++;
         prevInc = selInc;
      end
      checkOutput("rst_n low cycles", rstLow, RST_CYC);
      checkOutput("inc high cycles", incHi, PULSE_CYC*tgt);
      checkOutput("inc pulses", rises, tgt);
      checkOutput("rst_n timeline", badRst, 0);
      checkOutput("inc timeline", badInc, 0);
      checkOutput("ctrl_ena timeline", badEna, 0);
      mDone  = 1'b1;
      mCount = tgt;
   endtask

   task automatic runGo(input int tgt, input bit enaBit);
      logic [31:0] d;
      d = 32'h8000_0000 | (32'(enaBit) << 16) | 32'(tgt);
      wbWrite(A_CTRL, d, 4'hF);
      modelCtrlWrite(d, 4'hF, 1'b1);
      observeSeq(tgt, enaBit);
      readCheck("status after seq", A_STATUS, expStatus());
   endtask

   // One random register-level transaction checked against the model
   task automatic applyStimulus();
      int op;
      logic [31:0] d;
      logic [3:0] be;
      op = $urandom_range(0, 5);
      d  = $urandom;
      be = 4'($urandom_range(0, 15));
      case (op)
         0: begin wbWrite(A_SCRATCH, d, be); mScratch = mergeBytes(mScratch, d, be); end
         1: readCheck("rand scratch", A_SCRATCH, mScratch);
         2: begin be[3] = 1'b0; wbWrite(A_CTRL, d, be); modelCtrlWrite(d, be, 1'b1); end
         3: readCheck("rand ctrl", A_CTRL, expCtrl());
         4: begin
            wbWrite(A_STATUS, d, be);
            if (be[0]) begin
               if (d[1]) mDone = 1'b0;
               if (d[2]) mErr  = 1'b0;
            end
         end
         default: readCheck("rand status", A_STATUS, expStatus());
      endcase
   endtask

   initial begin
      logic [31:0] d;
      int nAck, nDat;

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("reset ack", {31'b0, ack}, 32'd0);
      checkOutput("reset dat", datOut, 32'd0);
      checkOutput("reset rst_n", {31'b0, selRstN}, 32'd0);
      checkOutput("reset inc", {31'b0, selInc}, 32'd0);
      checkOutput("reset ena", {31'b0, ena}, 32'd0);
      checkOutput("reset irq", {31'b0, irq}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_n after reset", {31'b0, selRstN}, 32'd1);
      readCheck("status reset", A_STATUS, 32'd0);
      readCheck("ctrl reset", A_CTRL, 32'd0);

      // Scratch byte enables
      wbWrite(A_SCRATCH, 32'hA5A5_5A5A, 4'b0101);
      mScratch = mergeBytes(mScratch, 32'hA5A5_5A5A, 4'b0101);
      readCheck("scratch sel0101", A_SCRATCH, 32'h00A5_005A);

      // Full sequence T=3 with enable, then T=0 without
      runGo(3, 1'b1);
      checkOutput("ctrl_ena T3", {31'b0, ena}, 32'd1);
      runGo(0, 1'b0);
      checkOutput("ctrl_ena T0", {31'b0, ena}, 32'd0);

      // Go while busy: sequence unaffected, err set, other fields written
      wbWrite(A_CTRL, 32'h8001_0002, 4'hF);
      modelCtrlWrite(32'h8001_0002, 4'hF, 1'b1);
      fork
         observeSeq(2, 1'b1);
         begin
            repeat (3) @(negedge clk);
            wbWrite(A_CTRL, 32'h8000_0005, 4'hF);
            modelCtrlWrite(32'h8000_0005, 4'hF, 1'b0);
         end
      join
      readCheck("status busy-go", A_STATUS, expStatus());
      readCheck("ctrl busy-go", A_CTRL, expCtrl());
      wbWrite(A_STATUS, 32'h6, 4'h1);
      mDone = 1'b0; mErr = 1'b0;
      readCheck("status w1c", A_STATUS, expStatus());

      // Reset during an increment pulse
      wbWrite(A_CTRL, 32'h8001_0003, 4'hF);
      for (int k = 0; k < 30 && !selInc; k++) @(negedge clk);
      checkOutput("inc before reset", {31'b0, selInc}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midreset rst_n", {31'b0, selRstN}, 32'd0);
      checkOutput("midreset inc", {31'b0, selInc}, 32'd0);
      checkOutput("midreset ena", {31'b0, ena}, 32'd0);
      checkOutput("midreset ack", {31'b0, ack}, 32'd0);
      rst = 1'b0;
      modelReset();
      @(negedge clk);
      checkOutput("post reset rst_n", {31'b0, selRstN}, 32'd1);
      readCheck("status post reset", A_STATUS, 32'd0);
      runGo(2, 1'b1);

      // Window decode
      adr = BASE + 32'h100; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
      nAck = 0; nDat = 0;
      repeat (4) begin
         @(negedge clk);
         if (ack) nAck++;
         if (datOut != 32'd0) nDat++;
      end
      stb = 1'b0; cyc = 1'b0;
      checkOutput("outside ack", nAck, 0);
      checkOutput("outside dat", nDat, 0);
      readCheck("reserved read", A_RSVD, 32'd0);
      wbWrite(A_RSVD, 32'hFFFF_FFFF, 4'hF);
      readCheck("scratch after rsvd", A_SCRATCH, mScratch);

      // Interrupt enable bit and irq output
      wbWrite(A_CTRL, 32'h0002_0000, 4'b0100);
      modelCtrlWrite(32'h0002_0000, 4'b0100, 1'b1);
      readCheck("ctrl irq_en", A_CTRL, expCtrl());
      runGo(1, 1'b0);
      checkOutput("irq after done", {31'b0, irq}, {31'b0, mDone & mCtrl[17]});

      // Random register traffic interleaved with random sequences
      for (int r = 0; r < 5; r++) begin
         for (int k = 0; k < 10; k++) applyStimulus();
         runGo($urandom_range(0, 4), 1'($urandom_range(0, 1)));
         checkOutput("rand irq", {31'b0, irq}, {31'b0, mDone & mCtrl[17]});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard time limit so the run always terminates
   initial begin
      #200000;
      $display("[TB] FAIL timeout: got 0x00000001 expected 0x00000000");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] time limit reached");
   end

endmodule
